// File: rtl/alu_pkg.sv
// Shared ALU opcodes, flag indices, issue FSM states, instruction field slices and decoder.
// Pure declarations; no timing and no backpressure.
package alu_pkg;
  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_ADDU = 8'h06;
  localparam logic [7:0] OP_ADDC = 8'h07;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_LSHI = 8'h0C;

  localparam int FLAG_Z = 4;
  localparam int FLAG_C = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_L = 0;

  localparam int OPHI_HI  = 15;
  localparam int OPHI_LO  = 12;
  localparam int RDEST_HI = 11;
  localparam int RDEST_LO = 8;
  localparam int OPEXT_HI = 7;
  localparam int OPEXT_LO = 4;
  localparam int RSRC_HI  = 3;
  localparam int RSRC_LO  = 0;
  localparam int IMM_HI   = 7;
  localparam int IMM_LO   = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WB    = 2'd2
  } issue_state_t;

  typedef struct packed {
    logic       legal;
    logic       use_imm;
    logic       sext;
    logic [7:0] opcode;
  } dec_t;

  function automatic dec_t decode_instr(input logic [15:0] instr);
    dec_t       d;
    logic [3:0] hi;
    logic [3:0] ext;
    hi  = instr[OPHI_HI:OPHI_LO];
    ext = instr[OPEXT_HI:OPEXT_LO];
    d   = '0;
    case (hi)
      4'h0: begin
        d.opcode = {4'h0, ext};
        d.legal  = !(ext inside {4'h8, 4'hA, 4'hD, 4'hE, 4'hF});
      end
      4'h5, 4'h7, 4'h9, 4'hB: begin
        d.opcode  = {4'h0, hi};
        d.legal   = 1'b1;
        d.use_imm = 1'b1;
        d.sext    = 1'b1;
      end
      4'h1, 4'h2, 4'h3, 4'h6: begin
        d.opcode  = {4'h0, hi};
        d.legal   = 1'b1;
        d.use_imm = 1'b1;
      end
      default: d = '0;
    endcase
    return d;
  endfunction
endpackage

// File: rtl/alu_issue_stage_regfile.sv
// Register file: two comb read ports, comb debug port, one sync write port, sync active-low reset.
// With ALU_ISSUE_R0_ZERO_EN defined, R0 reads as zero and writes to it are dropped.
module issue_regfile #(
  parameter int NREGS = 16,
  parameter int DW    = 16,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] rd_addr_a,
  output logic [DW-1:0] rd_data_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [DW-1:0] rd_data_b,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data
);
  logic [DW-1:0] mem [NREGS];
  logic          wr_ok;

`ifdef ALU_ISSUE_R0_ZERO_EN
  assign wr_ok     = wr_en && (wr_addr != '0);
  assign rd_data_a = (rd_addr_a == '0) ? '0 : mem[rd_addr_a];
  assign rd_data_b = (rd_addr_b == '0) ? '0 : mem[rd_addr_b];
  assign dbg_data  = (dbg_addr  == '0) ? '0 : mem[dbg_addr];
`else
  assign wr_ok     = wr_en;
  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];
  assign dbg_data  = mem[dbg_addr];
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end
endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue/writeback around an external ALU; 3-cycle IDLE->ISSUE->WB, update 2 cycles after accept.
// in_ready only in IDLE, so a held in_valid waits; R0 behaviour set by ALU_ISSUE_R0_ZERO_EN.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   in_instr,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [7:0]    alu_opcode,
  input  logic [DW-1:0] alu_c,
  input  logic [4:0]    alu_flags,
  output logic [4:0]    psr,
  output logic          wb_valid,
  output logic          illegal,
  input  logic [3:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
);
  issue_state_t  state, state_nx;
  logic [15:0]   instr_q;
  dec_t          dec;
  logic [DW-1:0] rd_a, rd_b, imm_ext;
  logic          wr_en, psr_en;

  assign dec     = decode_instr(instr_q);
  assign imm_ext = dec.sext ? {{(DW-8){instr_q[IMM_HI]}}, instr_q[IMM_HI:IMM_LO]}
                            : {{(DW-8){1'b0}}, instr_q[IMM_HI:IMM_LO]};

  // Writeback qualifiers come from the registered opcode so they line up with WB.
  assign psr_en = wb_valid && (alu_opcode != OP_NOP);
  assign wr_en  = psr_en && (alu_opcode[3:0] != OP_CMP[3:0]);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (in_valid) state_nx = ST_ISSUE;
      ST_ISSUE: state_nx = dec.legal ? ST_WB : ST_IDLE;
      ST_WB:    state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == ST_IDLE);
    wb_valid = (state == ST_WB);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      instr_q    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      illegal    <= 1'b0;
      psr        <= '0;
    end else begin
      illegal <= 1'b0;
      if (in_ready && in_valid) instr_q <= in_instr;
      if (state == ST_ISSUE) begin
        if (dec.legal) begin
          alu_a      <= rd_a;
          alu_b      <= dec.use_imm ? imm_ext : rd_b;
          alu_opcode <= dec.opcode;
        end else begin
          illegal <= 1'b1;
        end
      end
      if (psr_en) psr <= alu_flags;
    end
  end

  issue_regfile #(.NREGS(NREGS), .DW(DW)) u_regfile (
    .clk       (clk),
    .reset_n   (reset_n),
    .rd_addr_a (instr_q[RDEST_HI:RDEST_LO]),
    .rd_data_a (rd_a),
    .rd_addr_b (instr_q[RSRC_HI:RSRC_LO]),
    .rd_data_b (rd_b),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .wr_en     (wr_en),
    .wr_addr   (instr_q[RDEST_HI:RDEST_LO]),
    .wr_data   (alu_c)
  );
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a small behavioural ALU; honours ALU_ISSUE_R0_ZERO_EN.
module tb_alu_issue_stage;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_instr = '0;
  logic [15:0] alu_a, alu_b, alu_c;
  logic [7:0]  alu_opcode;
  logic [4:0]  alu_flags, psr;
  logic        wb_valid, illegal;
  logic [3:0]  dbg_addr = '0;
  logic [15:0] dbg_data;

  int tests = 0;
  int fails = 0;
  logic [15:0] rv;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_c(alu_c), .alu_flags(alu_flags), .psr(psr), .wb_valid(wb_valid),
    .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Behavioural ALU: flags {Z,C,F,N,L}; L only meaningful for compare.
  logic [16:0] sum;
  always_comb begin
    sum = '0;
    alu_c = '0;
    alu_flags = '0;
    case (alu_opcode)
      8'h01: alu_c = alu_a & alu_b;
      8'h02: alu_c = alu_a | alu_b;
      8'h03: alu_c = alu_a ^ alu_b;
      8'h05, 8'h06: begin
        sum = {1'b0, alu_a} + {1'b0, alu_b};
        alu_c = sum[15:0];
        alu_flags[3] = sum[16];
        alu_flags[2] = (alu_a[15] == alu_b[15]) && (alu_c[15] != alu_a[15]);
      end
      8'h09: begin
        sum = {1'b0, alu_a} - {1'b0, alu_b};
        alu_c = sum[15:0];
        alu_flags[3] = sum[16];
      end
      default: ;
    endcase
    if (alu_opcode == 8'h0B) begin
      alu_c = alu_a - alu_b;
      alu_flags[4] = (alu_a == alu_b);
      alu_flags[1] = ($signed(alu_a) < $signed(alu_b));
      alu_flags[0] = (alu_a < alu_b);
    end else if (alu_opcode != 8'h00) begin
      alu_flags[4] = (alu_c == 16'h0);
      alu_flags[1] = alu_c[15];
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic peek(input logic [3:0] a, output logic [15:0] d);
    dbg_addr = a;
    #1;
    d = dbg_data;
  endtask

  // Offer instr at a negedge in IDLE; returns #1 after the accept edge.
  task automatic accept(input logic [15:0] instr);
    @(negedge clk);
    chk("ready_before_accept", {15'b0, in_ready}, 16'h1);
    in_valid = 1'b1;
    in_instr = instr;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Full instruction: checks WB-cycle opcode/operand B and leaves us in the post-WB IDLE cycle.
  task automatic run(input string tag, input logic [15:0] instr,
                     input logic [7:0] exp_op, input logic [15:0] exp_b);
    accept(instr);
    @(negedge clk);
    chk({tag, "_wbv_issue"}, {15'b0, wb_valid}, 16'h0);
    @(negedge clk);
    chk({tag, "_wbv"}, {15'b0, wb_valid}, 16'h1);
    chk({tag, "_op"}, {8'h0, alu_opcode}, {8'h0, exp_op});
    chk({tag, "_b"}, alu_b, exp_b);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {15'b0, in_ready}, 16'h1);
    chk("rst_wbv", {15'b0, wb_valid}, 16'h0);
    chk("rst_illegal", {15'b0, illegal}, 16'h0);
    chk("rst_psr", {11'b0, psr}, 16'h0);
    chk("rst_op", {8'h0, alu_opcode}, 16'h0);
    chk("rst_a", alu_a, 16'h0);
    peek(4'd5, rv); chk("rst_r5", rv, 16'h0);
    reset_n = 1'b1;

    run("addi_r1", 16'h5105, 8'h05, 16'h0005);
    peek(4'd1, rv); chk("r1_5", rv, 16'h0005);
    chk("psr_addi", {11'b0, psr}, 16'h0000);

    run("addi_r2", 16'h52FF, 8'h05, 16'hFFFF);
    peek(4'd2, rv); chk("r2_m1", rv, 16'hFFFF);
    chk("psr_neg", {11'b0, psr}, 16'h0002);

    run("add_r1r2", 16'h0152, 8'h05, 16'hFFFF);
    peek(4'd1, rv); chk("r1_4", rv, 16'h0004);
    chk("psr_add", {11'b0, psr}, 16'h0008);

    run("addui_r3", 16'h63FF, 8'h06, 16'h00FF);
    peek(4'd3, rv); chk("r3_ff", rv, 16'h00FF);

    run("cmp_r1r2", 16'h01B2, 8'h0B, 16'hFFFF);
    peek(4'd1, rv); chk("cmp_r1_kept", rv, 16'h0004);
    chk("psr_cmp", {11'b0, psr}, 16'h0001);

    run("nop", 16'h0000, 8'h00, 16'h0000);
    chk("psr_nop_kept", {11'b0, psr}, 16'h0001);
    peek(4'd0, rv); chk("nop_r0", rv, 16'h0000);

    run("add_r3r3", 16'h0353, 8'h05, 16'h00FF);
    peek(4'd3, rv); chk("r3_self", rv, 16'h01FE);
    chk("psr_self", {11'b0, psr}, 16'h0000);

    // Undecodable instruction: single illegal pulse, ready back after 2 cycles.
    run("cmp_setpsr", 16'h01B2, 8'h0B, 16'hFFFF);
    accept(16'hF000);
    @(negedge clk);
    chk("ill_issue", {15'b0, illegal}, 16'h0);
    chk("ill_ready_issue", {15'b0, in_ready}, 16'h0);
    @(negedge clk);
    chk("ill_pulse", {15'b0, illegal}, 16'h1);
    chk("ill_ready_back", {15'b0, in_ready}, 16'h1);
    chk("ill_no_wb", {15'b0, wb_valid}, 16'h0);
    @(negedge clk);
    chk("ill_pulse_end", {15'b0, illegal}, 16'h0);
    chk("ill_psr_kept", {11'b0, psr}, 16'h0001);
    peek(4'd0, rv); chk("ill_r0", rv, 16'h0000);

    // in_valid held through a whole instruction; second instr waits for IDLE.
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = 16'h5401;
    @(posedge clk);
    #1 in_instr = 16'h5502;
    @(negedge clk);
    chk("hold_ready_issue", {15'b0, in_ready}, 16'h0);
    @(negedge clk);
    chk("hold_ready_wb", {15'b0, in_ready}, 16'h0);
    chk("hold_wbv", {15'b0, wb_valid}, 16'h1);
    @(negedge clk);
    chk("hold_ready_idle", {15'b0, in_ready}, 16'h1);
    peek(4'd4, rv); chk("hold_r4", rv, 16'h0001);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("hold2_issue", {15'b0, in_ready}, 16'h0);
    @(negedge clk);
    chk("hold2_b", alu_b, 16'h0002);
    @(negedge clk);
    peek(4'd5, rv); chk("hold_r5", rv, 16'h0002);

    // Reset during WB drops the write.
    accept(16'h5107);
    @(negedge clk);
    @(negedge clk);
    chk("rwb_wbv", {15'b0, wb_valid}, 16'h1);
    reset_n = 1'b0;
    @(negedge clk);
    peek(4'd1, rv); chk("rwb_r1", rv, 16'h0000);
    chk("rwb_ready", {15'b0, in_ready}, 16'h1);
    chk("rwb_psr", {11'b0, psr}, 16'h0);
    reset_n = 1'b1;

    run("addi_r0", 16'h5009, 8'h05, 16'h0009);
    peek(4'd0, rv);
`ifdef ALU_ISSUE_R0_ZERO_EN
    chk("r0_zero", rv, 16'h0000);
`else
    chk("r0_plain", rv, 16'h0009);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
